// File: rtl/axilite_slave_bridge_32x32.sv
// axilite_slave_bridge_32x32: AXI4-Lite responder converting each transaction into one local register-bus request
module axilite_slave_bridge_32x32 #(
  parameter int          C_AXI_DATA_WIDTH = 32,
  parameter int          C_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR        = 32'h0001_0000,
  parameter logic [31:0] ADDR_SPAN        = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES   = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   L_ADDR,
  output logic [C_AXI_DATA_WIDTH-1:0]   L_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] L_WSTRB,
  output logic                          L_WEN,
  output logic                          L_REN,
  input  logic [C_AXI_DATA_WIDTH-1:0]   L_RDATA,
  input  logic                          L_ACK,
  input  logic                          L_ERR
);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_REQ, WR_RESP, RD_ADDR, RD_REQ, RD_RESP} state_t;
  state_t state, state_n;
  logic aw_got, w_got, wr_pri, aw_hs, w_hs, both, in_win, tmo, done, unused;
  logic [AW-1:0] waddr_q, off;
  logic [DW/8-1:0] wstrb_q;
  logic [CW-1:0] cnt;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};
  assign aw_hs = state == WR_COLLECT && !aw_got && S_AXI_AWVALID;
  assign w_hs = state == WR_COLLECT && !w_got && S_AXI_WVALID;
  assign both = (aw_got | aw_hs) & (w_got | w_hs);
  // one subtractor serves both channels; an address below the base wraps high and fails the span test
  assign off = (state == RD_ADDR ? S_AXI_ARADDR : aw_got ? waddr_q : S_AXI_AWADDR) - AW'(BASE_ADDR);
  assign in_win = off < AW'(ADDR_SPAN);
  assign tmo = cnt == CW'(TIMEOUT_CYCLES);
  assign done = L_ACK | tmo;
  assign S_AXI_AWREADY = state == WR_COLLECT && !aw_got;
  assign S_AXI_WREADY = state == WR_COLLECT && !w_got;
  assign S_AXI_ARREADY = state == RD_ADDR;
  assign S_AXI_BVALID = state == WR_RESP;
  assign S_AXI_RVALID = state == RD_RESP;
  assign L_WEN = state == WR_REQ && cnt == '0;
  assign L_REN = state == RD_REQ && cnt == '0;
  assign L_WSTRB = state == WR_REQ ? wstrb_q : '0;
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       state_n = (S_AXI_AWVALID | S_AXI_WVALID) && (!S_AXI_ARVALID || wr_pri) ? WR_COLLECT :
                            S_AXI_ARVALID ? RD_ADDR : IDLE;
      WR_COLLECT: state_n = !both ? WR_COLLECT : in_win ? WR_REQ : WR_RESP;
      WR_REQ:     state_n = done ? WR_RESP : WR_REQ;
      WR_RESP:    state_n = S_AXI_BREADY ? IDLE : WR_RESP;
      RD_ADDR:    state_n = in_win ? RD_REQ : RD_RESP;
      RD_REQ:     state_n = done ? RD_RESP : RD_REQ;
      RD_RESP:    state_n = S_AXI_RREADY ? IDLE : RD_RESP;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      aw_got <= 1'b0;
      w_got <= 1'b0;
      wr_pri <= 1'b1;
      waddr_q <= '0;
      wstrb_q <= '0;
      cnt <= '0;
      L_ADDR <= '0;
      L_WDATA <= '0;
      S_AXI_BRESP <= 2'b00;
      S_AXI_RRESP <= 2'b00;
      S_AXI_RDATA <= '0;
    end else begin
      if (state == IDLE) begin
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      if (aw_hs) begin
        aw_got <= 1'b1;
        waddr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_got <= 1'b1;
        L_WDATA <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      cnt <= (state == WR_REQ || state == RD_REQ) ? cnt + 1'b1 : '0;
      if (((state == WR_COLLECT && both) || state == RD_ADDR) && in_win)
        L_ADDR <= {off[AW-1:2], 2'b00};
      if (state == WR_COLLECT && both && !in_win)
        S_AXI_BRESP <= 2'b11;
      if (state == WR_REQ && done)
        S_AXI_BRESP <= L_ACK ? {L_ERR, 1'b0} : 2'b10;
      if (state == RD_ADDR && !in_win) begin
        S_AXI_RRESP <= 2'b11;
        S_AXI_RDATA <= '0;
      end
      if (state == RD_REQ && done) begin
        S_AXI_RRESP <= L_ACK ? {L_ERR, 1'b0} : 2'b10;
        S_AXI_RDATA <= L_ACK ? L_RDATA : '0;
      end
      if (state == WR_RESP && S_AXI_BREADY)
        wr_pri <= 1'b0;
      if (state == RD_RESP && S_AXI_RREADY)
        wr_pri <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axilite_slave_bridge_32x32.sv
// tb_axilite_slave_bridge_32x32: directed checks of AXI4-Lite to local-bus bridging
module tb_axilite_slave_bridge_32x32;
  logic clock = 0, reset = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, l_addr, l_wdata, l_rdata = 0;
  logic [3:0] wstrb = 0, l_wstrb;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, l_wen, l_ren, l_ack = 0, l_err = 0;
  logic [1:0] bresp, rresp;
  int total = 0, bad = 0, wen_n = 0, ren_n = 0, w0, r0;
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (l_wen) wen_n <= wen_n + 1;
    if (l_ren) ren_n <= ren_n + 1;
  end
  axilite_slave_bridge_32x32 dut (
    .clock(clock), .reset(reset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .L_ADDR(l_addr), .L_WDATA(l_wdata), .L_WSTRB(l_wstrb), .L_WEN(l_wen), .L_REN(l_ren),
    .L_RDATA(l_rdata), .L_ACK(l_ack), .L_ERR(l_err)
  );
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic err, input logic [1:0] er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    cyc();
    chk("awready", awready, 1); chk("wready", wready, 1); chk("arready_wr", arready, 0);
    cyc();
    awvalid = 0; wvalid = 0;
    chk("wen", l_wen, 1); chk("laddr_w", l_addr, a - 32'h1_0000);
    chk("lwdata", l_wdata, d); chk("lwstrb", l_wstrb, s);
    l_ack = 1; l_err = err;
    cyc();
    l_ack = 0; l_err = 0;
    chk("bvalid", bvalid, 1); chk("bresp", bresp, er); chk("wen_off", l_wen, 0); chk("wstrb_off", l_wstrb, 0);
    bready = 1;
    cyc();
    bready = 0;
    chk("bclr", bvalid, 0);
  endtask
  task automatic do_rd(input logic [31:0] a, input int dly, input logic [31:0] d,
                       input logic err, input logic [1:0] er);
    araddr = a; arvalid = 1;
    cyc();
    chk("arready", arready, 1);
    cyc();
    arvalid = 0;
    chk("ren", l_ren, 1); chk("laddr_r", l_addr, a - 32'h1_0000); chk("arready_off", arready, 0);
    for (int i = 0; i < dly; i++) begin
      cyc();
      chk("rwait", rvalid, 0);
    end
    l_ack = 1; l_rdata = d; l_err = err;
    cyc();
    l_ack = 0; l_err = 0; l_rdata = 0;
    chk("rvalid", rvalid, 1); chk("rresp", rresp, er); chk("rdata", rdata, d);
    rready = 1;
    cyc();
    rready = 0;
    chk("rclr", rvalid, 0);
  endtask
  initial begin
    cyc(3);
    reset = 0;
    chk("rst_aw", awready, 0); chk("rst_w", wready, 0); chk("rst_ar", arready, 0);
    chk("rst_b", bvalid, 0); chk("rst_r", rvalid, 0); chk("rst_rdata", rdata, 0);
    chk("rst_resp", {bresp, rresp}, 0); chk("rst_l", {l_wen, l_ren, l_wstrb}, 0);
    chk("rst_laddr", l_addr, 0); chk("rst_lwdata", l_wdata, 0);
    w0 = wen_n;
    do_wr(32'h1_0004, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
    chk("wen_once", wen_n - w0, 1);
    r0 = ren_n;
    do_rd(32'h1_C000, 5, 32'h8765_4321, 0, 2'b00);
    chk("ren_once", ren_n - r0, 1);
    w0 = wen_n; r0 = ren_n;
    araddr = 32'h3_0000; arvalid = 1;
    cyc();
    chk("dec_arready", arready, 1);
    cyc();
    arvalid = 0;
    chk("dec_rvalid", rvalid, 1); chk("dec_rresp", rresp, 2'b11); chk("dec_rdata", rdata, 0);
    rready = 1;
    cyc();
    rready = 0;
    awaddr = 32'h0_FFFC; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cyc(2);
    awvalid = 0; wvalid = 0;
    chk("dec_bvalid", bvalid, 1); chk("dec_bresp", bresp, 2'b11);
    bready = 1;
    cyc();
    bready = 0;
    chk("dec_nolocal", {wen_n - w0, ren_n - r0}, 0);
    awaddr = 32'h1_0008; wdata = 32'hCAFE_F00D; awvalid = 1; wvalid = 1;
    cyc(2);
    awvalid = 0; wvalid = 0;
    chk("to_wen", l_wen, 1);
    cyc();
    chk("to_wen_pulse", l_wen, 0); chk("to_wstrb_held", l_wstrb, 4'hF);
    cyc(63);
    chk("to_early", bvalid, 0);
    cyc();
    chk("to_bvalid", bvalid, 1); chk("to_bresp", bresp, 2'b10);
    bready = 1;
    cyc();
    bready = 0;
    cyc(9);
    l_ack = 1;
    cyc();
    l_ack = 0;
    cyc(3);
    chk("stray_ack", {bvalid, rvalid, l_wen, l_ren}, 0);
    w0 = wen_n;
    wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1;
    cyc();
    chk("wfirst_wready", wready, 1);
    cyc();
    wvalid = 0;
    chk("wfirst_wdone", wready, 0); chk("wfirst_awready", awready, 1);
    cyc();
    awaddr = 32'h1_0010; awvalid = 1;
    cyc();
    awvalid = 0;
    chk("late_wen", l_wen, 1); chk("late_addr", l_addr, 32'h10); chk("late_strb", l_wstrb, 4'h3);
    l_ack = 1;
    cyc();
    l_ack = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bhold_v", bvalid, 1); chk("bhold_r", bresp, 2'b00);
      if (i < 3) cyc();
    end
    bready = 1;
    cyc();
    bready = 0;
    chk("bhold_clr", bvalid, 0); chk("late_wen_once", wen_n - w0, 1);
    do_wr(32'h1_0014, 32'h0BAD_0BAD, 4'hF, 1, 2'b10);
    reset = 1;
    cyc();
    reset = 0;
    arvalid = 1; araddr = 32'h1_0020;
    do_wr(32'h1_0018, 32'hAAAA_0001, 4'hF, 0, 2'b00);
    do_rd(32'h1_0020, 0, 32'h0000_A5A5, 0, 2'b00);
    arvalid = 1; araddr = 32'h1_0024;
    do_wr(32'h1_001C, 32'hAAAA_0002, 4'hF, 0, 2'b00);
    cyc();
    chk("rr_arready", arready, 1);
    cyc();
    chk("rr_ren", l_ren, 1);
    arvalid = 0; reset = 1;
    cyc();
    reset = 0;
    chk("mid_rst_laddr", l_addr, 0); chk("mid_rst_lwdata", l_wdata, 0);
    chk("mid_rst_out", {bvalid, rvalid, arready, awready, wready, bresp, rresp}, 0);
    cyc(3);
    chk("mid_rst_norv", rvalid, 0);
    do_rd(32'h1_0040, 1, 32'h5555_AAAA, 0, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
